// File: rtl/writeback_arbiter_if.sv
// Writeback arbiter bus: pipeline and multdiv result inputs, hazard probes, register file write port.
// The master side drives results and probes. The slave side is the arbiter.
interface writeback_arbiter_if;
   logic        pipe_valid;
   logic [4:0]  pipe_rd;
   logic [31:0] pipe_data;
   logic        md_valid;
   logic [4:0]  md_rd;
   logic [31:0] md_data;
   logic        md_ready;
   logic [4:0]  chk_regA;
   logic [4:0]  chk_regB;
   logic        busyA;
   logic        busyB;
   logic        ctrl_writeEnable;
   logic [4:0]  ctrl_writeReg;
   logic [31:0] data_writeReg;

   modport master (
      output pipe_valid, pipe_rd, pipe_data,
      output md_valid, md_rd, md_data,
      output chk_regA, chk_regB,
      input  md_ready, busyA, busyB,
      input  ctrl_writeEnable, ctrl_writeReg, data_writeReg
   );

   modport slave (
      input  pipe_valid, pipe_rd, pipe_data,
      input  md_valid, md_rd, md_data,
      input  chk_regA, chk_regB,
      output md_ready, busyA, busyB,
      output ctrl_writeEnable, ctrl_writeReg, data_writeReg
   );
endinterface

// File: rtl/writeback_arbiter.sv
// Single register-file write port shared by the pipeline and a queued multdiv unit.
// Optional macro WB_MD_BYPASS_EN lets a multdiv result skip an empty queue.
module writeback_arbiter #(
   parameter int DEPTH = 2
) (
   input logic                clock,
   input logic                ctrl_reset,
   writeback_arbiter_if.slave wb
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [4:0]       q_rd_reg   [DEPTH];
   logic [31:0]      q_data_reg [DEPTH];
   logic [DEPTH-1:0] q_val_reg, q_val_next;
   logic [PTR_W-1:0] head_reg, head_next;
   logic [PTR_W-1:0] tail_reg, tail_next;
   logic [CNT_W-1:0] count_reg, count_next;

   logic        we_reg, we_next;
   logic [4:0]  wreg_reg, wreg_next;
   logic [31:0] wdata_reg, wdata_next;

   logic             pipe_sel, not_empty, head_live;
   logic             pop, md_take, bypass, push, md_ready_int;
   logic [DEPTH-1:0] squash, hit_a, hit_b;

   assign pipe_sel     = wb.pipe_valid && (wb.pipe_rd != 5'd0);
   assign not_empty    = (count_reg != '0);
   assign head_live    = q_val_reg[head_reg];
   assign md_ready_int = (count_reg < CNT_W'(DEPTH));
   assign md_take      = wb.md_valid && md_ready_int && (wb.md_rd != 5'd0);
   // A squashed head is dropped even while the pipeline owns the port.
   assign pop          = not_empty && (!pipe_sel || !head_live);

`ifdef WB_MD_BYPASS_EN
   assign bypass = md_take && !not_empty && !pipe_sel;
`else
   assign bypass = 1'b0;
`endif
   assign push = md_take && !bypass;

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
         assign squash[gi] = pipe_sel && q_val_reg[gi] && (q_rd_reg[gi] == wb.pipe_rd);
         assign hit_a[gi]  = q_val_reg[gi] && (q_rd_reg[gi] == wb.chk_regA);
         assign hit_b[gi]  = q_val_reg[gi] && (q_rd_reg[gi] == wb.chk_regB);
      end
   endgenerate

   assign wb.md_ready         = md_ready_int;
   assign wb.busyA            = (|hit_a) && (wb.chk_regA != 5'd0);
   assign wb.busyB            = (|hit_b) && (wb.chk_regB != 5'd0);
   assign wb.ctrl_writeEnable = we_reg;
   assign wb.ctrl_writeReg    = wreg_reg;
   assign wb.data_writeReg    = wdata_reg;

   always_comb begin
      we_next    = 1'b0;
      wreg_next  = wreg_reg;
      wdata_next = wdata_reg;
      if (pipe_sel) begin
         we_next    = 1'b1;
         wreg_next  = wb.pipe_rd;
         wdata_next = wb.pipe_data;
      end else if (pop && head_live) begin
         we_next    = 1'b1;
         wreg_next  = q_rd_reg[head_reg];
         wdata_next = q_data_reg[head_reg];
      end else if (bypass) begin
         we_next    = 1'b1;
         wreg_next  = wb.md_rd;
         wdata_next = wb.md_data;
      end
   end

   // The tail slot is never occupied when pushing, so a new entry escapes the squash.
   always_comb begin
      q_val_next = q_val_reg & ~squash;
      if (pop)
         q_val_next[head_reg] = 1'b0;
      if (push)
         q_val_next[tail_reg] = 1'b1;
      head_next  = head_reg + PTR_W'(pop);
      tail_next  = tail_reg + PTR_W'(push);
      count_next = count_reg + CNT_W'(push) - CNT_W'(pop);
   end

   always_ff @(posedge clock or posedge ctrl_reset) begin
      if (ctrl_reset) begin
         q_val_reg <= '0;
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= '0;
         we_reg    <= 1'b0;
         wreg_reg  <= 5'd0;
         wdata_reg <= 32'd0;
      end else begin
         q_val_reg <= q_val_next;
         head_reg  <= head_next;
         tail_reg  <= tail_next;
         count_reg <= count_next;
         we_reg    <= we_next;
         wreg_reg  <= wreg_next;
         wdata_reg <= wdata_next;
      end
   end

   // Payload storage needs no reset; the valid bits qualify every slot.
   always_ff @(posedge clock) begin
      if (push) begin
         q_rd_reg[tail_reg]   <= wb.md_rd;
         q_data_reg[tail_reg] <= wb.md_data;
      end
   end
endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter (DEPTH=2); follows WB_MD_BYPASS_EN for latency expectations.
module tb_writeback_arbiter;
   logic clock;
   logic ctrl_reset;
   int   checks = 0;
   int   passes = 0;

   writeback_arbiter_if wb();

   writeback_arbiter #(.DEPTH(2)) dut (
      .clock      (clock),
      .ctrl_reset (ctrl_reset),
      .wb         (wb.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) begin
      #1;
      if (wb.ctrl_writeEnable)
         $display("write r%0d = 0x%08h", wb.ctrl_writeReg, wb.data_writeReg);
   end

   function automatic logic [37:0] wr();
      return {wb.ctrl_writeEnable, wb.ctrl_writeReg, wb.data_writeReg};
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      wb.chk_regA = 5'd7;
      wb.chk_regB = 5'd0;
      tick();
      tick();
      checks++;
      if (wr() !== {1'b0, 5'd0, 32'd0}) $display("FAIL reset_write: got %h want %h", wr(), {1'b0, 5'd0, 32'd0});
      else passes++;
      checks++;
      if (wb.md_ready !== 1'b1) $display("FAIL reset_md_ready: got %b want 1", wb.md_ready);
      else passes++;
      checks++;
      if ({wb.busyA, wb.busyB} !== 2'b00) $display("FAIL reset_busy: got %b want 00", {wb.busyA, wb.busyB});
      else passes++;
      ctrl_reset = 1'b0;
      tick();
      checks++;
      if (wb.ctrl_writeEnable !== 1'b0) $display("FAIL post_reset_idle: got we=%b want 0", wb.ctrl_writeEnable);
      else passes++;
   endtask

   task automatic test_pipe_write();
      wb.pipe_valid = 1'b1; wb.pipe_rd = 5'd5; wb.pipe_data = 32'hDEADBEEF;
      tick();
      wb.pipe_valid = 1'b0;
      checks++;
      if (wr() !== {1'b1, 5'd5, 32'hDEADBEEF}) $display("FAIL pipe_write: got %h want %h", wr(), {1'b1, 5'd5, 32'hDEADBEEF});
      else passes++;
      tick();
      checks++;
      if (wr() !== {1'b0, 5'd5, 32'hDEADBEEF}) $display("FAIL pipe_hold: got %h want %h", wr(), {1'b0, 5'd5, 32'hDEADBEEF});
      else passes++;
   endtask

   task automatic test_md_behind_pipe();
      wb.pipe_valid = 1'b1; wb.pipe_rd = 5'd3; wb.pipe_data = 32'h33;
      wb.md_valid = 1'b1; wb.md_rd = 5'd7; wb.md_data = 32'h11;
      wb.chk_regA = 5'd7;
      for (int i = 0; i < 3; i++) begin
         tick();
         wb.md_valid = 1'b0;
         if (i == 2) wb.pipe_valid = 1'b0;
         checks++;
         if (wr() !== {1'b1, 5'd3, 32'h33}) $display("FAIL md_wait_pipe%0d: got %h want %h", i, wr(), {1'b1, 5'd3, 32'h33});
         else passes++;
         checks++;
         if (wb.busyA !== 1'b1) $display("FAIL md_busyA%0d: got %b want 1", i, wb.busyA);
         else passes++;
      end
      tick();
      checks++;
      if (wr() !== {1'b1, 5'd7, 32'h11}) $display("FAIL md_drain: got %h want %h", wr(), {1'b1, 5'd7, 32'h11});
      else passes++;
      checks++;
      if (wb.busyA !== 1'b0) $display("FAIL md_busyA_clear: got %b want 0", wb.busyA);
      else passes++;
      tick();
      checks++;
      if (wb.ctrl_writeEnable !== 1'b0) $display("FAIL md_idle: got we=%b want 0", wb.ctrl_writeEnable);
      else passes++;
   endtask

   task automatic test_fill();
      wb.chk_regA = 5'd0;
      wb.pipe_valid = 1'b1; wb.pipe_rd = 5'd3; wb.pipe_data = 32'h33;
      wb.md_valid = 1'b1; wb.md_rd = 5'd10; wb.md_data = 32'hA0;
      tick();
      wb.md_rd = 5'd11; wb.md_data = 32'hB0;
      checks++;
      if (wb.md_ready !== 1'b1) $display("FAIL fill_ready1: got %b want 1", wb.md_ready);
      else passes++;
      tick();
      wb.md_rd = 5'd12; wb.md_data = 32'hC0;
      checks++;
      if (wb.md_ready !== 1'b0) $display("FAIL fill_full: got %b want 0", wb.md_ready);
      else passes++;
      tick();
      checks++;
      if (wb.md_ready !== 1'b0) $display("FAIL fill_still_full: got %b want 0", wb.md_ready);
      else passes++;
      wb.pipe_valid = 1'b0;
      tick();
      checks++;
      if (wr() !== {1'b1, 5'd10, 32'hA0}) $display("FAIL fill_first: got %h want %h", wr(), {1'b1, 5'd10, 32'hA0});
      else passes++;
      checks++;
      if (wb.md_ready !== 1'b1) $display("FAIL fill_ready_after_pop: got %b want 1", wb.md_ready);
      else passes++;
      tick();
      wb.md_valid = 1'b0;
      checks++;
      if (wr() !== {1'b1, 5'd11, 32'hB0}) $display("FAIL fill_second: got %h want %h", wr(), {1'b1, 5'd11, 32'hB0});
      else passes++;
      tick();
      checks++;
      if (wr() !== {1'b1, 5'd12, 32'hC0}) $display("FAIL fill_third: got %h want %h", wr(), {1'b1, 5'd12, 32'hC0});
      else passes++;
      tick();
      checks++;
      if (wb.ctrl_writeEnable !== 1'b0) $display("FAIL fill_idle: got we=%b want 0", wb.ctrl_writeEnable);
      else passes++;
   endtask

   task automatic test_squash();
      wb.chk_regB = 5'd9;
      wb.pipe_valid = 1'b1; wb.pipe_rd = 5'd3; wb.pipe_data = 32'h33;
      wb.md_valid = 1'b1; wb.md_rd = 5'd9; wb.md_data = 32'hAA;
      tick();
      wb.md_valid = 1'b0;
      wb.pipe_rd = 5'd9; wb.pipe_data = 32'hBB;
      #1;
      checks++;
      if (wb.busyB !== 1'b1) $display("FAIL squash_busy_before: got %b want 1", wb.busyB);
      else passes++;
      tick();
      wb.pipe_valid = 1'b0;
      checks++;
      if (wr() !== {1'b1, 5'd9, 32'hBB}) $display("FAIL squash_pipe: got %h want %h", wr(), {1'b1, 5'd9, 32'hBB});
      else passes++;
      checks++;
      if (wb.busyB !== 1'b0) $display("FAIL squash_busy_after: got %b want 0", wb.busyB);
      else passes++;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if (wr() !== {1'b0, 5'd9, 32'hBB}) $display("FAIL squash_no_write%0d: got %h want %h", i, wr(), {1'b0, 5'd9, 32'hBB});
         else passes++;
      end
      wb.chk_regB = 5'd0;
   endtask

   task automatic test_push_vs_squash();
      wb.chk_regA = 5'd4;
      wb.pipe_valid = 1'b1; wb.pipe_rd = 5'd4; wb.pipe_data = 32'h44;
      wb.md_valid = 1'b1; wb.md_rd = 5'd4; wb.md_data = 32'h45;
      tick();
      wb.pipe_valid = 1'b0; wb.md_valid = 1'b0;
      checks++;
      if (wr() !== {1'b1, 5'd4, 32'h44}) $display("FAIL same_rd_pipe: got %h want %h", wr(), {1'b1, 5'd4, 32'h44});
      else passes++;
      checks++;
      if (wb.busyA !== 1'b1) $display("FAIL same_rd_kept: got %b want 1", wb.busyA);
      else passes++;
      tick();
      checks++;
      if (wr() !== {1'b1, 5'd4, 32'h45}) $display("FAIL same_rd_md: got %h want %h", wr(), {1'b1, 5'd4, 32'h45});
      else passes++;
      tick();
      wb.chk_regA = 5'd0;
   endtask

   task automatic test_zero_rd();
      wb.pipe_valid = 1'b1; wb.pipe_rd = 5'd0; wb.pipe_data = 32'h99;
      wb.md_valid = 1'b1; wb.md_rd = 5'd0; wb.md_data = 32'h98;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if (wr() !== {1'b0, 5'd4, 32'h45}) $display("FAIL zero_rd_write%0d: got %h want %h", i, wr(), {1'b0, 5'd4, 32'h45});
         else passes++;
         checks++;
         if (wb.md_ready !== 1'b1) $display("FAIL zero_rd_ready%0d: got %b want 1", i, wb.md_ready);
         else passes++;
      end
      wb.pipe_rd = 5'd3; wb.pipe_data = 32'h33;
      wb.md_rd = 5'd6; wb.md_data = 32'h66;
      tick();
      wb.md_valid = 1'b0;
      wb.pipe_rd = 5'd0;
      checks++;
      if (wr() !== {1'b1, 5'd3, 32'h33}) $display("FAIL zero_rd_setup: got %h want %h", wr(), {1'b1, 5'd3, 32'h33});
      else passes++;
      tick();
      wb.pipe_valid = 1'b0;
      checks++;
      if (wr() !== {1'b1, 5'd6, 32'h66}) $display("FAIL zero_rd_head_wins: got %h want %h", wr(), {1'b1, 5'd6, 32'h66});
      else passes++;
      tick();
   endtask

   task automatic test_reset_mid();
      wb.pipe_valid = 1'b1; wb.pipe_rd = 5'd3; wb.pipe_data = 32'h33;
      wb.md_valid = 1'b1; wb.md_rd = 5'd20; wb.md_data = 32'h20;
      tick();
      wb.md_rd = 5'd21; wb.md_data = 32'h21;
      tick();
      wb.md_valid = 1'b0; wb.pipe_valid = 1'b0;
      wb.chk_regA = 5'd20; wb.chk_regB = 5'd21;
      #1;
      checks++;
      if (wb.md_ready !== 1'b0) $display("FAIL mid_full: got %b want 0", wb.md_ready);
      else passes++;
      checks++;
      if ({wb.busyA, wb.busyB} !== 2'b11) $display("FAIL mid_busy: got %b want 11", {wb.busyA, wb.busyB});
      else passes++;
      ctrl_reset = 1'b1;
      #1;
      checks++;
      if (wr() !== {1'b0, 5'd0, 32'd0}) $display("FAIL mid_reset_write: got %h want %h", wr(), {1'b0, 5'd0, 32'd0});
      else passes++;
      checks++;
      if ({wb.md_ready, wb.busyA, wb.busyB} !== 3'b100) $display("FAIL mid_reset_flags: got %b want 100", {wb.md_ready, wb.busyA, wb.busyB});
      else passes++;
      tick();
      ctrl_reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (wr() !== {1'b0, 5'd0, 32'd0}) $display("FAIL mid_no_write%0d: got %h want %h", i, wr(), {1'b0, 5'd0, 32'd0});
         else passes++;
      end
      checks++;
      if (wb.md_ready !== 1'b1) $display("FAIL mid_ready: got %b want 1", wb.md_ready);
      else passes++;
      wb.md_valid = 1'b1; wb.md_rd = 5'd8; wb.md_data = 32'h88;
      tick();
      wb.md_valid = 1'b0;
`ifdef WB_MD_BYPASS_EN
      checks++;
      if (wr() !== {1'b1, 5'd8, 32'h88}) $display("FAIL lat_edge1: got %h want %h", wr(), {1'b1, 5'd8, 32'h88});
      else passes++;
      tick();
      checks++;
      if (wr() !== {1'b0, 5'd8, 32'h88}) $display("FAIL lat_edge2: got %h want %h", wr(), {1'b0, 5'd8, 32'h88});
      else passes++;
`else
      checks++;
      if (wr() !== {1'b0, 5'd0, 32'd0}) $display("FAIL lat_edge1: got %h want %h", wr(), {1'b0, 5'd0, 32'd0});
      else passes++;
      tick();
      checks++;
      if (wr() !== {1'b1, 5'd8, 32'h88}) $display("FAIL lat_edge2: got %h want %h", wr(), {1'b1, 5'd8, 32'h88});
      else passes++;
`endif
   endtask

   initial begin
      ctrl_reset    = 1'b1;
      wb.pipe_valid = 1'b0; wb.pipe_rd = 5'd0; wb.pipe_data = 32'd0;
      wb.md_valid   = 1'b0; wb.md_rd   = 5'd0; wb.md_data   = 32'd0;
      wb.chk_regA   = 5'd0; wb.chk_regB = 5'd0;
      test_reset();
      test_pipe_write();
      test_md_behind_pipe();
      test_fill();
      test_squash();
      test_push_vs_squash();
      test_zero_rd();
      test_reset_mid();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 Parameter: DEPTH, default 2, number of multdiv result queue entries; SHALL be a power of two, 2..8.
REQ-002 Port: clock  in  1  single clock; all state updates on rising edge.
REQ-003 Port: ctrl_reset  in  1  asynchronous, active-high reset.
REQ-004 Port: pipe_valid  in  1  pipeline writeback result present this cycle.
REQ-005 Port: pipe_rd  in  5  pipeline destination register.
REQ-006 Port: pipe_data  in  32  pipeline result value.
REQ-007 Port: md_valid  in  1  multdiv result offered.
REQ-008 Port: md_rd  in  5  multdiv destination register.
REQ-009 Port: md_data  in  32  multdiv result value.
REQ-010 Port: md_ready  out  1  queue can accept; high when occupancy < DEPTH.
REQ-011 Port: chk_regA, chk_regB  in  5 each  source registers being decoded.
REQ-012 Port: busyA, busyB  out  1 each  a valid queued entry targets chk_regA/chk_regB; always 0 for register 0.
REQ-013 Port: ctrl_writeEnable  out  1  register file write enable, registered.
REQ-014 Port: ctrl_writeReg  out  5  register file write address, registered.
REQ-015 Port: data_writeReg  out  32  register file write data, registered.

Function
REQ-016 Each cycle SHALL select at most one write source: pipeline first, else queue head, else none.
REQ-017 Selected write SHALL appear on ctrl_writeEnable/ctrl_writeReg/data_writeReg after the next rising edge; with no selection, ctrl_writeEnable SHALL be 0 and address/data SHALL hold their last values.
REQ-018 Pipeline write with pipe_rd = 0 SHALL be discarded: no write, no queue effect, and the queue head may be selected that cycle.
REQ-019 Multdiv handshake: transfer occurs when md_valid & md_ready at a rising edge; md_rd = 0 transfers SHALL be accepted and dropped (not enqueued).
REQ-020 Queue SHALL be FIFO-ordered; pop occurs only when the head is selected per REQ-016.
REQ-021 Simultaneous push and pop in one cycle SHALL be allowed, occupancy unchanged; md_ready SHALL use pre-edge occupancy (full queue does not accept even when popping).
REQ-022 WAW squash: when a pipeline write with nonzero pipe_rd is selected, every valid queued entry with the same rd SHALL be invalidated that edge; an invalidated head SHALL be popped without a write.
REQ-023 An entry being pushed in the same cycle as a matching pipeline write SHALL NOT be squashed.
REQ-024 busyA/busyB SHALL be combinational from current queue contents and chk_reg inputs, ignoring invalidated entries.
REQ-025 Queue pointers SHALL wrap modulo DEPTH; occupancy SHALL never exceed DEPTH or underflow below 0.

Reset
REQ-026 While ctrl_reset is high: queue empty, all entries invalid, ctrl_writeEnable = 0, ctrl_writeReg = 0, data_writeReg = 0, md_ready = 1, busyA = busyB = 0.
REQ-027 Reset asserted mid-operation SHALL discard all queued results without issuing writes.
REQ-028 First write after reset deassertion SHALL occur no earlier than the edge after the first qualifying input.

Configuration
REQ-029 Macro WB_MD_BYPASS_EN: when defined, a multdiv transfer with nonzero md_rd that arrives while the queue is empty and no pipeline write is selected SHALL bypass the queue and be written in the same cycle (1-edge latency).
REQ-030 Without WB_MD_BYPASS_EN, every accepted multdiv result SHALL be enqueued first (minimum 2-edge latency).

Verification
REQ-031 Reset, then pipe_valid=1, rd=5, data=0xDEADBEEF for 1 cycle -> next edge: WE=1, reg=5, data=0xDEADBEEF; following edge: WE=0.
REQ-032 md push rd=7 data=0x11 with pipe_valid held high (rd=3) for 3 cycles -> md write to r7 issued only in the cycle after pipe_valid drops; busyA=1 while chk_regA=7.
REQ-033 Fill queue (DEPTH=2) with pipe_valid held high -> md_ready=0; a third offer is held by the producer, not lost; all three writes occur in order once pipe_valid drops.
REQ-034 Queue holds rd=9 data=0xAA; pipe write rd=9 data=0xBB -> only r9=0xBB written; queue empty, busy for r9 = 0.
REQ-035 pipe rd=0 and md rd=0 offered -> no ctrl_writeEnable pulse; md_ready stays 1.
REQ-036 Queue holds 2 entries; assert ctrl_reset for 1 cycle -> no writes issued afterward; md_ready=1. Repeat with and without WB_MD_BYPASS_EN, checking 1- vs 2-edge md latency on an empty queue.
